// File: rtl/mult_div_pkg.sv
// Shared encodings and sizing for the multicycle multiply/divide unit and the control
// unit that waits on it.
package mult_div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } md_state_e;

  localparam int unsigned DefaultWidth = 32;

  // Holds 0..WIDTH without wrapping inside one operation.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned CntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/mult_div_if.sv
// Request/response bundle between the CPU control unit (master) and the mult/div unit.
interface mult_div_if #(
  parameter int unsigned WIDTH = mult_div_pkg::DefaultWidth
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a_in, b_in,
    input  busy, done, hi_out, lo_out, div_zero
  );

  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output busy, done, hi_out, lo_out, div_zero
  );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on {A, Q, q_-1}: conditional add/subtract of M, then an
// arithmetic shift right by one.
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    // One guard bit so that subtracting the most negative M cannot overflow.
    a_ext = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
    m_ext = {m_i[WIDTH-1], m_i};
    unique case (acc_i[1:0])
      2'b01:   sum = a_ext + m_ext;
      2'b10:   sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase
    acc_o = {sum, acc_i[WIDTH:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth) / divide (restoring) unit with HI/LO result
// registers, MIPS mult/div semantics.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH + 1;

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dz_q, dz_d;

  logic [AccW-1:0]  booth_acc;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_sh;
  logic             r_neg;
  logic [WIDTH-1:0] r_next, q_next;
  logic             last_iter;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_booth_step (
    .acc_i(acc_q),
    .m_i  (m_q),
    .acc_o(booth_acc)
  );

  assign a_mag = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign b_mag = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

  // Divide reuses the accumulator as {R, Q, unused}; m_q holds |b|.
  assign r_sh   = {acc_q[2*WIDTH:WIDTH+1], acc_q[WIDTH]};
  assign r_neg  = r_sh < {1'b0, m_q};
  assign r_next = r_neg ? r_sh[WIDTH-1:0] : (r_sh[WIDTH-1:0] - m_q);
  assign q_next = {acc_q[WIDTH-1:1], ~r_neg};

  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_mult) begin
          state_d = StMult;
          cnt_d   = '0;
          dz_d    = 1'b0;
          m_d     = bus.a_in;
          acc_d   = {WIDTH'(0), bus.b_in, 1'b0};
        end else if (bus.start_div) begin
          cnt_d = '0;
          if (bus.b_in == '0) begin
            state_d = StDone;
            dz_d    = 1'b1;
          end else begin
            state_d = StDiv;
            dz_d    = 1'b0;
            m_d     = b_mag;
            acc_d   = {WIDTH'(0), a_mag, 1'b0};
            qsign_d = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            rsign_d = bus.a_in[WIDTH-1];
          end
        end
      end
      StMult: begin
        acc_d = booth_acc;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          hi_d    = booth_acc[2*WIDTH:WIDTH+1];
          lo_d    = booth_acc[WIDTH:1];
          state_d = StDone;
        end
      end
      StDiv: begin
        acc_d = {r_next, q_next, 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          lo_d    = qsign_q ? -q_next : q_next;
          hi_d    = rsign_q ? -r_next : r_next;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q == StMult) || (state_q == StDiv);
  assign bus.done     = (state_q == StDone);
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: expected HI/LO/div_zero, latency and busy
// length are queued at request time and compared when done pulses.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           busy;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [W-1:0] last_hi, last_lo;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: builds the expectation and pushes it to the scoreboard.
  task automatic push_expect(input bit mul, input bit dv, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    exp_t e;
    longint p;
    int sa, sbv, q, r;
    sa  = $signed(a);
    sbv = $signed(b);
    if (mul) begin
      p    = longint'(sa) * longint'(sbv);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
      e.lat = W;
      e.busy = W;
    end else if (b == '0) begin
      e.hi = last_hi;
      e.lo = last_lo;
      e.dz = 1'b1;
      e.lat = 0;
      e.busy = 0;
    end else begin
      if (a == 32'h8000_0000 && sbv == -1) begin
        q = sa;
        r = 0;
      end else begin
        q = sa / sbv;
        r = sa % sbv;
      end
      e.hi = r;
      e.lo = q;
      e.dz = 1'b0;
      e.lat = W;
      e.busy = W;
    end
    last_hi = e.hi;
    last_lo = e.lo;
    sb_q.push_back(e);
  endtask

  // Issue one request; optionally pulse a stray start_mult while busy (inject_at >= 0).
  task automatic do_op(input string tag, input bit mul, input bit dv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int inject_at);
    int n, busy_cnt;
    bit got;
    exp_t e;
    @(negedge clk);
    bus.start_mult = mul;
    bus.start_div  = dv;
    bus.a_in       = a;
    bus.b_in       = b;
    push_expect(mul, dv, a, b);
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in       = $urandom;
    bus.b_in       = $urandom;
    n = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (n == inject_at) begin
          bus.start_mult = 1'b1;
          bus.a_in       = 32'h0000_0005;
          bus.b_in       = 32'h0000_0009;
        end else if (n == inject_at + 1) begin
          bus.start_mult = 1'b0;
        end
        @(posedge clk);
        #1;
        n++;
      end
    end
    bus.start_mult = 1'b0;
    e = sb_q.pop_front();
    check({tag, " done seen"}, 64'(got), 64'(1));
    check({tag, " latency"}, 64'(n), 64'(e.lat));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(e.busy));
    check({tag, " hi"}, 64'(bus.hi_out), 64'(e.hi));
    check({tag, " lo"}, 64'(bus.lo_out), 64'(e.lo));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, 64'(bus.done), 64'(0));
    check({tag, " hi hold"}, 64'(bus.hi_out), 64'(e.hi));
    check({tag, " lo hold"}, 64'(bus.lo_out), 64'(e.lo));
  endtask

  initial begin
    int done_seen;
    checks = 0;
    errors = 0;
    last_hi = '0;
    last_lo = '0;
    reset = 1'b0;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset hi", 64'(bus.hi_out), 64'(0));
    check("reset lo", 64'(bus.lo_out), 64'(0));
    check("reset div_zero", 64'(bus.div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    do_op("mult 7*-3", 1, 0, 32'h0000_0007, 32'hFFFF_FFFD, -1);
    do_op("mult max*max", 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
    do_op("mult min*min", 1, 0, 32'h8000_0000, 32'h8000_0000, -1);
    do_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'h0000_0002, -1);
    do_op("div 7/-2", 0, 1, 32'h0000_0007, 32'hFFFF_FFFE, -1);
    do_op("div 5/0", 0, 1, 32'h0000_0005, 32'h0000_0000, -1);
    do_op("mult after dz", 1, 0, 32'hFFFF_FFFF, 32'h0000_0010, -1);
    do_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op("mult+div same cycle", 1, 1, 32'h0000_0003, 32'h0000_0004, -1);
    do_op("div 100/-7", 0, 1, 32'h0000_0064, 32'hFFFF_FFF9, -1);

    // Abort a multiply with an asynchronous reset partway through.
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.a_in = 32'h1234_5678;
    bus.b_in = 32'h0000_0100;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort hi", 64'(bus.hi_out), 64'(0));
    check("abort lo", 64'(bus.lo_out), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    last_hi = '0;
    last_lo = '0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'(0));

    do_op("mult with stray start", 1, 0, 32'hFFFF_FF00, 32'h0000_0123, 5);
    do_op("div with stray start", 0, 1, 32'h8000_0001, 32'h0000_0003, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide responder for the CPU datapath. The control unit raises a one-cycle start, holds its FSM in a wait state while busy is high, and resumes on done. Results are held in internal HI/LO registers that feed the datapath muxes for mfhi/mflo. The block implements the MIPS semantics of mult and div.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; an iteration takes WIDTH cycles

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_mult  input  1  one-cycle request: signed multiply a_in*b_in
start_div  input  1  one-cycle request: signed divide a_in/b_in
a_in  input  WIDTH  operand A (multiplicand / dividend); sampled only at the accepting edge
b_in  input  WIDTH  operand B (multiplier / divisor); sampled only at the accepting edge
busy  output  1  high while an operation iterates
done  output  1  one-cycle pulse; hi_out/lo_out are valid during it
hi_out  output  WIDTH  product high half / remainder
lo_out  output  WIDTH  product low half / quotient
div_zero  output  1  last accepted div had b_in==0

Behaviour:
- Reset asserted (reset low), asynchronously: state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0.
- Reset asserted mid-operation aborts the operation. No done is issued.
- FSM states: IDLE, MULT, DIV, DONE. busy=1 in MULT/DIV only. done=1 in DONE only. Both are decoded from the registered state.
- IDLE:
  - A start is accepted only in IDLE. Starts in MULT, DIV or DONE are ignored.
  - start_mult and start_div high together: mult wins and start_div is dropped.
  - On accept at edge k: latch operands, counter=0, div_zero cleared.
  - Mult path: go to MULT.
  - Div path with b_in!=0: latch |a|, |b|, quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]); go to DIV.
  - Div path with b_in==0: go to DONE, div_zero=1, hi/lo unchanged, done high in the cycle after edge k.
- MULT (radix-2 Booth):
  - Accumulator is 2*WIDTH+1 bits: {A, Q, q_-1}.
  - Each edge: add +M, add -M, or no-op per {Q[0], q_-1}, then arithmetic shift right by 1; counter++.
  - At the WIDTH-th iteration edge (k+WIDTH): the combinational result of that iteration loads hi_out=product[2W-1:W] and lo_out=product[W-1:0]; state goes to DONE.
- DIV (restoring, on magnitudes):
  - Each edge: shift {R, Q} left, trial subtract R-|b|, restore if negative, set the quotient bit; counter++.
  - At edge k+WIDTH: lo_out=quotient negated if its sign is 1; hi_out=remainder negated if the dividend was negative. State goes to DONE.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case -2^(W-1)/-1 yields lo=0x80000000, hi=0, with no flag.
- DONE: lasts one cycle, then IDLE. The earliest next accepted start is at edge k+WIDTH+2.
- Latency: done is high during the cycle after edge k+WIDTH (mult/div) or after edge k (divide by zero).
- hi_out/lo_out change only at the loading edge. They hold indefinitely otherwise, including across ignored starts.
- div_zero holds until the next accepted start.
- Counter width is clog2(WIDTH)+1 and never wraps within one operation.

Decomposition:
- Shared package mult_div_pkg holds:
  - state encodings (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3);
  - default WIDTH;
  - the counter-width constant.
- The control unit uses the same package for its wait-state handshake.
- One sub-module is natural: booth_step. It is purely combinational: one Booth add/shift on {A,Q,q_-1} and M.
- The divide iteration stays inline.

Test Plan:
1. mult 7 * 0xFFFFFFFD (-3): done exactly at cycle k+33 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
2. mult 0x7FFFFFFF * 0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001. Then mult 0x80000000 * 0x80000000 → hi=0x40000000, lo=0.
3. div 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 7 / 0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
4. div 5 / 0 → done one cycle after start, div_zero=1, hi/lo keep the prior values. A following mult clears div_zero.
5. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Same-cycle start_mult+start_div with 3,4 → mult result lo=12, hi=0.
6. Assert reset low at iteration 10 of a mult → outputs immediately 0, no done. A start_mult pulse during busy of a later op is ignored and the result is unaffected.
